// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: timestep sequencer placed upstream of lstm_top.
// Buffers up to MAX_STEPS x vectors. On run it issues one lstm_top start per
// buffered vector, in load order. Each step's y_out is fed back as the next
// step's y_in, starting from a zero state. After the last step it presents the
// final hidden state together with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_valid/ready/data x-vector load handshake (lane i at [i*DATA_WIDTH +: DATA_WIDTH])
//   run                   start processing every buffered vector
//   busy, done            sequence in progress / one-cycle completion pulse
//   h_final               final hidden state, valid from done, held until next done
//   step_idx              index of the timestep currently issued
//   lstm_start/x/y_in     request side toward lstm_top
//   lstm_finished/y_out   completion side from lstm_top
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 4,
  parameter int MAX_STEPS  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [VEC_LEN*DATA_WIDTH-1:0] load_data,
  input  logic                          run,
  output logic                          busy,
  output logic                          done,
  output logic [VEC_LEN*DATA_WIDTH-1:0] h_final,
  output logic [$clog2(MAX_STEPS)-1:0]  step_idx,
  output logic                          lstm_start,
  output logic [VEC_LEN*DATA_WIDTH-1:0] lstm_x,
  output logic [VEC_LEN*DATA_WIDTH-1:0] lstm_y_in,
  input  logic                          lstm_finished,
  input  logic [VEC_LEN*DATA_WIDTH-1:0] lstm_y_out
);

  localparam int VW = VEC_LEN * DATA_WIDTH;
  localparam int SW = $clog2(MAX_STEPS);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_STEPS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SW-1:0] STEP_ONE = SW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [SW-1:0]   step;
  logic [VW-1:0]   h_reg;
  logic [VW-1:0]   h_final_q;
  logic [VW-1:0]   buf_mem [MAX_STEPS];
  logic            accept;
  logic            run_go;
  logic            last_step;

  // A beat accepted in the same cycle as run counts toward the sequence.
  always_comb begin
    accept    = load_valid && load_ready;
    run_go    = (state == IDLE) && run && ((count != '0) || accept);
    last_step = (({1'b0, step}) + CNT_ONE) == count;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (run_go) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (lstm_finished) state_nxt = last_step ? DONE : ISSUE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. h_final shows h_reg directly during DONE so the result is
  // visible in the done cycle, then the latched copy holds it afterwards.
  always_comb begin
    load_ready = (state == IDLE) && (count < CNT_MAX);
    busy       = (state != IDLE);
    done       = (state == DONE);
    lstm_start = (state == ISSUE);
    h_final    = (state == DONE) ? h_reg : h_final_q;
    step_idx   = step;
  end

  // Sequence buffer: no reset, contents are only read below count.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[count[SW-1:0]] <= load_data;
  end

  // Datapath. lstm_x / lstm_y_in are loaded on the edge entering ISSUE so they
  // are already valid alongside lstm_start and stay put through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      step      <= '0;
      h_reg     <= '0;
      h_final_q <= '0;
      lstm_x    <= '0;
      lstm_y_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) count <= count + CNT_ONE;
          if (run_go) begin
            step      <= '0;
            h_reg     <= '0;
            lstm_y_in <= '0;
            // With an empty buffer the only vector is the one arriving now.
            lstm_x    <= (count == '0) ? load_data : buf_mem[0];
          end
        end
        WAIT: begin
          if (lstm_finished) begin
            h_reg <= lstm_y_out;
            if (!last_step) begin
              step      <= step + STEP_ONE;
              lstm_x    <= buf_mem[step + STEP_ONE];
              lstm_y_in <= lstm_y_out;
            end
          end
        end
        DONE: begin
          count     <= '0;
          h_final_q <= h_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
module tb_lstm_seq_ctrl;

  localparam int DW  = 8;
  localparam int VL  = 4;
  localparam int MS  = 8;
  localparam int VW  = DW * VL;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [VW-1:0] load_data;
  logic          run;
  logic          busy;
  logic          done;
  logic [VW-1:0] h_final;
  logic [2:0]    step_idx;
  logic          lstm_start;
  logic [VW-1:0] lstm_x;
  logic [VW-1:0] lstm_y_in;
  logic          lstm_finished;
  logic [VW-1:0] lstm_y_out;

  logic          resp_fin  = 1'b0;
  logic          stray_fin = 1'b0;
  logic [VW-1:0] resp_y    = '0;
  logic [VW-1:0] junk_y    = '0;

  assign lstm_finished = resp_fin | stray_fin;
  assign lstm_y_out    = stray_fin ? junk_y : resp_y;

  lstm_seq_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(VL), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .run(run), .busy(busy), .done(done), .h_final(h_final), .step_idx(step_idx),
    .lstm_start(lstm_start), .lstm_x(lstm_x), .lstm_y_in(lstm_y_in),
    .lstm_finished(lstm_finished), .lstm_y_out(lstm_y_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [VW-1:0] mq[$];    // vectors the buffer should hold
  logic [VW-1:0] seq[$];   // sequence of the current run
  logic [VW-1:0] exp_h;
  int            exp_step = 0;
  int            starts   = 0;
  int            pend     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] vadd(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    for (int i = 0; i < VL; i++) r[i*DW +: DW] = a[i*DW +: DW] + b[i*DW +: DW];
    return r;
  endfunction

  function automatic logic [VW-1:0] mkvec(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  // lstm_top stand-in: y_out = x + y_in lane-wise, finished LAT cycles after start.
  // Also checks every issued step against the reference sequence.
  initial begin
    forever begin
      @(negedge clk);
      resp_fin = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) resp_fin = 1'b1;
        end
        if (lstm_start) begin
          starts++;
          resp_y = vadd(lstm_x, lstm_y_in);
          pend   = LAT;
          if (exp_step < seq.size()) begin
            check("x", lstm_x, seq[exp_step]);
            check("y_in", lstm_y_in, exp_h);
            check("step_idx", step_idx, exp_step[2:0]);
            exp_h = vadd(seq[exp_step], exp_h);
            exp_step++;
          end else begin
            check("extra_start", starts, seq.size());
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, load_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_start"}, lstm_start, 0);
    check({tag, "_hfinal"}, h_final, 0);
    check({tag, "_x"}, lstm_x, 0);
    check({tag, "_yin"}, lstm_y_in, 0);
    check({tag, "_step"}, step_idx, 0);
  endtask

  task automatic load_beat(input logic [VW-1:0] v);
    load_valid = 1'b1;
    load_data  = v;
    check("load_ready", load_ready, (mq.size() < MS) ? 1 : 0);
    if (mq.size() < MS) mq.push_back(v);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic begin_run();
    seq      = mq;
    exp_h    = '0;
    exp_step = 0;
    starts   = 0;
    run      = 1'b1;
    @(negedge clk);
    run      = 1'b0;
  endtask

  // Runs the buffered sequence to completion; stray=1 also pokes lstm_finished
  // in the ISSUE cycle and offers load beats during WAIT.
  task automatic run_seq(input int stray, output logic [VW-1:0] hf);
    int            cyc;
    int            n;
    logic [VW-1:0] hm;
    n  = mq.size();
    hm = '0;
    foreach (mq[i]) hm = vadd(mq[i], hm);
    begin_run();
    cyc = 1;
    check("busy_after_run", busy, 1);
    if (stray != 0) begin
      stray_fin = 1'b1;
      junk_y    = $urandom;
      @(negedge clk);
      stray_fin = 1'b0;
      cyc++;
      load_valid = 1'b1;
      load_data  = $urandom;
      check("ready_in_wait", load_ready, 0);
      @(negedge clk);
      cyc++;
      check("ready_in_wait2", load_ready, 0);
      load_valid = 1'b0;
    end
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
    hf = h_final;
    if (done) begin
      check("latency", cyc, n * (LAT + 1) + 1);
      check("h_final", h_final, hm);
      check("starts", starts, n);
      check("busy_in_done", busy, 1);
    end
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_clear", busy, 0);
    check("h_hold", h_final, hm);
    check("ready_after", load_ready, 1);
    mq.delete();
  endtask

  initial begin
    logic [VW-1:0] hf;
    int            n;
    int            w;
    int            saw_done;

    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; run = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_rel");

    // run with an empty buffer is ignored
    begin_run();
    check("empty_busy", busy, 0);
    check("empty_start", lstm_start, 0);
    repeat (3) @(negedge clk);
    check("empty_starts", starts, 0);
    check("empty_busy2", busy, 0);

    // two-step directed sequence
    load_beat(mkvec(8'h25, 8'h35, 8'hF5, 8'hEB));
    load_beat(mkvec(8'h2D, 8'hBC, 8'h29, 8'h57));
    run_seq(0, hf);
    check("two_step_h", hf, mkvec(8'h52, 8'hF1, 8'h1E, 8'h42));

    // full buffer plus three dropped beats
    for (int i = 0; i < MS + 3; i++) load_beat($urandom);
    run_seq(0, hf);

    // stray finished in IDLE, then stray finished in ISSUE and loads in WAIT
    w = starts;
    stray_fin = 1'b1;
    junk_y    = $urandom;
    @(negedge clk);
    stray_fin = 1'b0;
    @(negedge clk);
    check("stray_idle_busy", busy, 0);
    check("stray_idle_start", lstm_start, 0);
    check("stray_idle_ready", load_ready, 1);
    check("stray_idle_starts", starts, w);
    for (int i = 0; i < 3; i++) load_beat($urandom);
    run_seq(1, hf);

    // reset during WAIT of step 1 of 4
    for (int i = 0; i < 4; i++) load_beat($urandom);
    begin_run();
    w = 0;
    while (starts < 2 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("reach_step1", starts, 2);
    @(negedge clk);
    check("mid_step", step_idx, 1);
    check("mid_wait", lstm_start, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    mq.delete();
    repeat (LAT + 3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("midrst_no_done", saw_done, 0);
    check_reset_vals("midrst_idle");
    for (int i = 0; i < 4; i++) load_beat($urandom);
    run_seq(0, hf);

    // back-to-back: single vector, no carry-over of the previous state
    load_beat(mkvec(8'h01, 8'h02, 8'h03, 8'h04));
    run_seq(0, hf);
    check("b2b_h", hf, mkvec(8'h01, 8'h02, 8'h03, 8'h04));

    // randomized sequences
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, MS);
      for (int i = 0; i < n; i++) load_beat($urandom);
      run_seq(0, hf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
